// File: rtl/cnn_loadseq_pkg.sv
// Shared definitions for the CNN layer load sequencer: accelerator region map,
// FSM state and operand phase encodings.
package cnn_loadseq_pkg;

  localparam logic [31:0] RESULT_BASE    = 32'hd000_0000;
  localparam logic [31:0] IMAGE_SET_BASE = 32'hd111_0000;
  localparam logic [31:0] INTERRUPT_BASE = 32'hd222_0000;
  localparam logic [31:0] WEIGHT_BASE    = 32'hd333_0000;
  localparam logic [31:0] BIAS_BASE      = 32'hd444_0000;
  localparam logic [31:0] PIXEL_BASE     = 32'hd555_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_GAP,
    S_WAIT_IRQ,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    PH_WEIGHT,
    PH_BIAS,
    PH_PIXEL
  } phase_t;

  function automatic logic [31:0] region_base(input phase_t ph);
    case (ph)
      PH_WEIGHT: region_base = WEIGHT_BASE;
      PH_BIAS:   region_base = BIAS_BASE;
      default:   region_base = PIXEL_BASE;
    endcase
  endfunction

endpackage

// File: rtl/loadseq_word_counter.sv
// Up-counter with synchronous clear/enable and a compare against a runtime
// terminal value; used for the word, gap and watchdog counts.
module loadseq_word_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] terminal,
  output logic [W-1:0] count,
  output logic         tc
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign tc    = (count_q == terminal);

endmodule

// File: rtl/cnn_load_sequencer.sv
// Streams weights, biases and pixels from the source memory into the
// accelerator slave port, then waits for its interrupt. Optional watchdog:
// define LOADSEQ_TIMEOUT_EN.
module cnn_load_sequencer
  import cnn_loadseq_pkg::*;
#(
  parameter int WEIGHT_WORDS   = 792,
  parameter int BIAS_WORDS     = 16,
  parameter int PIXEL_WORDS    = 6144,
  parameter int GAP            = 3,
  parameter int SRC_AW         = 16,
  parameter int TIMEOUT_CYCLES = 40000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic              src_rd_en,
  output logic [SRC_AW-1:0] src_addr,
  input  logic [31:0]       src_rdata,
  output logic [31:0]       awaddr,
  output logic              awvalid,
  output logic [31:0]       wdata,
  output logic              wvalid,
  input  logic              interrupt_signal
);

  localparam bit                HAS_GAP   = (GAP > 0);
  localparam logic [3:0]        GAP_LAST  = 4'(GAP - 1);
  localparam logic [SRC_AW-1:0] BIAS_IDX  = SRC_AW'(WEIGHT_WORDS);
  localparam logic [SRC_AW-1:0] PIXEL_IDX = SRC_AW'(WEIGHT_WORDS + BIAS_WORDS);

  state_t state_q, state_d;
  phase_t phase_q, phase_d;
  logic   last_q, last_d;
  logic   busy_q, busy_d;
  logic   done_q, done_d;
  logic   rd_en_q, rd_en_d;
  logic   wvalid_q, wvalid_d;

  logic              wcnt_clr, wcnt_en, wcnt_tc;
  logic [SRC_AW-1:0] wcnt, wcnt_last, phase_idx;
  logic              gcnt_clr, gcnt_en, gcnt_tc;
  logic [3:0]        gcnt;

  always_comb begin
    wcnt_last = SRC_AW'(PIXEL_WORDS - 1);
    phase_idx = PIXEL_IDX;
    case (phase_q)
      PH_WEIGHT: begin
        wcnt_last = SRC_AW'(WEIGHT_WORDS - 1);
        phase_idx = '0;
      end
      PH_BIAS: begin
        wcnt_last = SRC_AW'(BIAS_WORDS - 1);
        phase_idx = BIAS_IDX;
      end
      default: ;
    endcase
  end

  loadseq_word_counter #(.W(SRC_AW)) u_word_cnt (
    .clk(clk), .rst(rst), .clr(wcnt_clr), .en(wcnt_en),
    .terminal(wcnt_last), .count(wcnt), .tc(wcnt_tc)
  );

  loadseq_word_counter #(.W(4)) u_gap_cnt (
    .clk(clk), .rst(rst), .clr(gcnt_clr), .en(gcnt_en),
    .terminal(GAP_LAST), .count(gcnt), .tc(gcnt_tc)
  );

`ifdef LOADSEQ_TIMEOUT_EN
  logic        timeout_q, timeout_d;
  logic        wd_clr, wd_en, wd_tc;
  logic [31:0] wd_cnt;

  loadseq_word_counter #(.W(32)) u_wd_cnt (
    .clk(clk), .rst(rst), .clr(wd_clr), .en(wd_en),
    .terminal(32'(TIMEOUT_CYCLES - 1)), .count(wd_cnt), .tc(wd_tc)
  );
`endif

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    last_d   = last_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    rd_en_d  = 1'b0;
    wvalid_d = 1'b0;
    wcnt_clr = 1'b0;
    wcnt_en  = 1'b0;
    gcnt_clr = 1'b0;
    gcnt_en  = 1'b0;
`ifdef LOADSEQ_TIMEOUT_EN
    timeout_d = timeout_q;
    wd_clr    = 1'b0;
    wd_en     = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_RD;
          rd_en_d  = 1'b1;
          busy_d   = 1'b1;
          phase_d  = PH_WEIGHT;
          last_d   = 1'b0;
          wcnt_clr = 1'b1;
`ifdef LOADSEQ_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
        end
      end
      S_RD: begin
        state_d  = S_WR;
        wvalid_d = 1'b1;
      end
      S_WR: begin
        // last_d marks that the final pixel has just gone out
        if (wcnt_tc) begin
          wcnt_clr = 1'b1;
          if (phase_q == PH_WEIGHT) phase_d = PH_BIAS;
          else                      phase_d = PH_PIXEL;
          if (phase_q == PH_PIXEL)  last_d  = 1'b1;
        end else begin
          wcnt_en = 1'b1;
        end
        if (HAS_GAP) begin
          state_d  = S_GAP;
          gcnt_clr = 1'b1;
        end else if (wcnt_tc && phase_q == PH_PIXEL) begin
          state_d = S_WAIT_IRQ;
`ifdef LOADSEQ_TIMEOUT_EN
          wd_clr = 1'b1;
`endif
        end else begin
          state_d = S_RD;
          rd_en_d = 1'b1;
        end
      end
      S_GAP: begin
        if (gcnt_tc) begin
          if (last_q) begin
            state_d = S_WAIT_IRQ;
`ifdef LOADSEQ_TIMEOUT_EN
            wd_clr = 1'b1;
`endif
          end else begin
            state_d = S_RD;
            rd_en_d = 1'b1;
          end
        end else begin
          gcnt_en = 1'b1;
        end
      end
      S_WAIT_IRQ: begin
        if (interrupt_signal) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
`ifdef LOADSEQ_TIMEOUT_EN
        end else if (wd_tc) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          timeout_d = 1'b1;
        end else begin
          wd_en = 1'b1;
`endif
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      phase_q  <= PH_WEIGHT;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_en_q  <= 1'b0;
      wvalid_q <= 1'b0;
`ifdef LOADSEQ_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rd_en_q  <= rd_en_d;
      wvalid_q <= wvalid_d;
`ifdef LOADSEQ_TIMEOUT_EN
      timeout_q <= timeout_d;
`endif
    end
  end

  // Read data arrives the cycle after the read, so wdata passes straight through.
  assign busy      = busy_q;
  assign done      = done_q;
  assign src_rd_en = rd_en_q;
  assign src_addr  = rd_en_q ? (phase_idx + wcnt) : '0;
  assign awvalid   = wvalid_q;
  assign wvalid    = wvalid_q;
  assign awaddr    = wvalid_q ? region_base(phase_q) : 32'h0;
  assign wdata     = wvalid_q ? src_rdata : 32'h0;
`ifdef LOADSEQ_TIMEOUT_EN
  assign timeout   = timeout_q;
`else
  assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_cnn_load_sequencer.sv
// Directed bench: a GAP=3 instance and a GAP=0 instance, 3/2/4-word layer,
// source[i] = 32'h100 + i.
module tb_cnn_load_sequencer;

  localparam int AW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, start0, irq, irq0;
  logic          busy, done, timeout, rd_en, awvalid, wvalid;
  logic          busy0, done0, timeout0, rd_en0, awvalid0, wvalid0;
  logic [AW-1:0] addr, addr0;
  logic [31:0]   rdata, awaddr, wdata, rdata0, awaddr0, wdata0;

  cnn_load_sequencer #(.WEIGHT_WORDS(3), .BIAS_WORDS(2), .PIXEL_WORDS(4), .GAP(3),
                       .SRC_AW(AW), .TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .timeout(timeout),
    .src_rd_en(rd_en), .src_addr(addr), .src_rdata(rdata), .awaddr(awaddr),
    .awvalid(awvalid), .wdata(wdata), .wvalid(wvalid), .interrupt_signal(irq));

  cnn_load_sequencer #(.WEIGHT_WORDS(3), .BIAS_WORDS(2), .PIXEL_WORDS(4), .GAP(0),
                       .SRC_AW(AW), .TIMEOUT_CYCLES(50)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0), .timeout(timeout0),
    .src_rd_en(rd_en0), .src_addr(addr0), .src_rdata(rdata0), .awaddr(awaddr0),
    .awvalid(awvalid0), .wdata(wdata0), .wvalid(wvalid0), .interrupt_signal(irq0));

  always @(posedge clk) begin
    if (rd_en)  rdata  <= 32'h100 + 32'(addr);
    if (rd_en0) rdata0 <= 32'h100 + 32'(addr0);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] la [64], ld [64], la0 [64], ld0 [64];
  int          lc [64], lc0 [64];
  logic        lv [64], lv0 [64];
  int          ln = 0, ln0 = 0;

  always @(negedge clk) begin
    if (wvalid) begin
      if (ln < 64) begin la[ln] = awaddr; ld[ln] = wdata; lc[ln] = cyc; lv[ln] = awvalid; end
      ln++;
    end
    if (wvalid0) begin
      if (ln0 < 64) begin la0[ln0] = awaddr0; ld0[ln0] = wdata0; lc0[ln0] = cyc; lv0[ln0] = awvalid0; end
      ln0++;
    end
  end

  logic [31:0] exp_a [9] = '{32'hd333_0000, 32'hd333_0000, 32'hd333_0000,
                             32'hd444_0000, 32'hd444_0000,
                             32'hd555_0000, 32'hd555_0000, 32'hd555_0000, 32'hd555_0000};
  logic [31:0] exp_d [9] = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h104,
                             32'h105, 32'h106, 32'h107, 32'h108};

  int passed = 0, total = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic check_load(input string tag, input logic [31:0] a [64], input logic [31:0] d [64],
                            input int c [64], input logic v [64], input int nb, input int nn,
                            input int t0, input int period);
    chk({tag, "_count"}, 64'(nn - nb), 64'd9);
    for (int i = 0; i < 9; i++) begin
      if (nb + i < 64) begin
        $display("%s write %0d: cyc=%0d awaddr=%h wdata=%h", tag, i + 1, c[nb+i] - t0, a[nb+i], d[nb+i]);
        chk({tag, "_awaddr"}, 64'(a[nb+i]), 64'(exp_a[i]));
        chk({tag, "_wdata"}, 64'(d[nb+i]), 64'(exp_d[i]));
        chk({tag, "_cycle"}, 64'(c[nb+i] - t0), 64'(2 + period * i));
        chk({tag, "_awvalid"}, 64'(v[nb+i]), 64'd1);
      end
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ctl"}, 64'({busy, done, timeout, rd_en, awvalid, wvalid}), 64'd0);
    chk({tag, "_bus"}, {awaddr, wdata}, 64'd0);
    chk({tag, "_addr"}, 64'(addr), 64'd0);
  endtask

  int t_a, t_b, t_c, n_a, m_a, n_b, n_c;

  initial begin
    rst = 1'b1; start = 1'b0; start0 = 1'b0; irq = 1'b0; irq0 = 1'b0;
    tick(); tick(); tick();
    chk_idle("reset");
    chk("reset0_ctl", 64'({busy0, done0, timeout0, rd_en0, wvalid0}), 64'd0);
    rst = 1'b0;
    tick();

    // Full load on both instances; start-while-busy and early interrupts.
    n_a = ln; m_a = ln0; t_a = cyc;
    start = 1'b1; start0 = 1'b1;
    tick();
    start = 1'b0; start0 = 1'b0;
    chk("accept_busy", 64'({busy, rd_en}), 64'b11);
    chk("accept_addr", 64'(addr), 64'd0);
    chk("accept_busy0", 64'(busy0), 64'd1);
    while (cyc < t_a + 66) begin
      start = (cyc == t_a + 12);
      irq   = (cyc >= t_a + 30 && cyc < t_a + 34);
      irq0  = (cyc >= t_a + 10 && cyc < t_a + 21);
      if (cyc == t_a + 19) chk("gap0_wait_irq", 64'({busy0, done0}), 64'b10);
      if (cyc == t_a + 20) chk("gap0_done_early_irq", 64'({busy0, done0}), 64'b01);
      if (cyc == t_a + 21) chk("gap0_idle", 64'({busy0, done0}), 64'b00);
      if (cyc >= t_a + 46) chk("wait_irq_busy", 64'({busy, done, wvalid, rd_en}), 64'b1000);
      tick();
    end
    start = 1'b0;
    irq = 1'b1;
    tick();
    irq = 1'b0;
    chk("irq_done", 64'({busy, done}), 64'b01);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("after_done", 64'({busy, done}), 64'b00);
    tick();
    chk("start_in_done_ignored", 64'({busy, rd_en}), 64'b00);
    check_load("load", la, ld, lc, lv, n_a, ln, t_a, 5);
    check_load("gap0", la0, ld0, lc0, lv0, m_a, ln0, t_a, 2);

    // Reset during the gap after write 5, then a clean restart.
    tick();
    n_b = ln; t_b = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_to(t_b + 23);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle("rst_mid");
    chk("rst_mid_writes", 64'(ln - n_b), 64'd5);
    tick();
    chk("rst_no_resume", 64'({busy, rd_en, wvalid}), 64'd0);

    n_c = ln; t_c = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_to(t_c + 2);
    chk("restart_first", {awaddr, wdata}, {32'hd333_0000, 32'h100});
    wait_to(t_c + 50);
    check_load("restart", la, ld, lc, lv, n_c, ln, t_c, 5);

`ifdef LOADSEQ_TIMEOUT_EN
    wait_to(t_c + 95);
    chk("wd_before", 64'({busy, done, timeout}), 64'b100);
    tick();
    chk("wd_fire", 64'({busy, done, timeout}), 64'b011);
    tick();
    chk("wd_sticky", 64'({busy, done, timeout}), 64'b001);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("wd_clear_on_start", 64'({busy, timeout}), 64'b10);
`else
    wait_to(t_c + 100);
    chk("no_wd_waits", 64'({busy, done, timeout}), 64'b100);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
